acc_sched: RTL and testbench

- Sequences and shares one `acc` instance (MODE=0, external RELEASE) among LANES requesters.
- Each requester delivers a dot-product partial of TERMS float16 terms.
- The scheduler:
  - grants one lane at a time by round-robin and streams that lane's burst into `acc`;
  - asserts RELEASE on the burst's first term;
  - tags the returning DVO stream so each final sum goes back out with its lane index.

---
 rtl/acc_sched_pkg.sv | 32 +++
 rtl/acc_sched_arbiter.sv | 48 ++++
 rtl/acc_sched.sv | 171 +++++++++++++++++
 tb/tb_acc_sched.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_sched_pkg.sv
// Shared types and constants for the acc_sched accumulator scheduler.
// Optional build macro ACC_SCHED_FIXED_PRIO_EN switches arbitration to fixed priority.
package acc_sched_pkg;

  localparam int FP16_W = 16;
  localparam int TYPE_W = 6;
  localparam int LANE_W = 3;

  localparam logic [TYPE_W-1:0] TYPE_NORM = 6'b100000;
  localparam logic [TYPE_W-1:0] TYPE_ZERO = 6'b001000;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  typedef struct packed {
    logic              vld;
    logic              last;
    logic [LANE_W-1:0] lane;
  } tag_t;

  // Lane index plus one, wrapping at the lane count.
  function automatic logic [LANE_W-1:0] nextLane(input logic [LANE_W-1:0] idx,
                                                 input int unsigned       lanes);
    logic [LANE_W:0] s;
    s = {1'b0, idx} + 1'b1;
    if (s >= (LANE_W+1)'(lanes)) s = '0;
    return s[LANE_W-1:0];
  endfunction

endpackage

// File: rtl/acc_sched_arbiter.sv
// Request arbiter: first requester at or after ptr_i wins (round-robin), or the lowest
// index wins when ACC_SCHED_FIXED_PRIO_EN is defined (ptr_i is then ignored).
module rr_arbiter
  import acc_sched_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic [LANES-1:0]  req_i,
  input  logic [LANE_W-1:0] ptr_i,
  output logic [LANES-1:0]  gnt_o,
  output logic [LANE_W-1:0] idx_o,
  output logic              any_o
);

`ifdef ACC_SCHED_FIXED_PRIO_EN
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = LANE_W'(i);
        any_o = 1'b1;
      end
    end
    gnt_o = any_o ? (LANES'(1) << idx_o) : '0;
  end
`else
  logic [LANES-1:0]  reqRot;
  logic [LANE_W:0]   idxSum;

  // Rotate so the pointer lane sits at bit 0, pick the lowest set bit, then un-rotate.
  always_comb begin
    reqRot = LANES'({req_i, req_i} >> ptr_i);
    idxSum = '0;
    any_o  = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (reqRot[i]) begin
        idxSum = {1'b0, ptr_i} + (LANE_W+1)'(i);
        any_o  = 1'b1;
      end
    end
    if (idxSum >= (LANE_W+1)'(LANES)) idxSum = idxSum - (LANE_W+1)'(LANES);
    idx_o = idxSum[LANE_W-1:0];
    gnt_o = any_o ? (LANES'(1) << idx_o) : '0;
  end
`endif

endmodule

// File: rtl/acc_sched.sv
// Shares one accumulator among LANES requesters, one TERMS-long burst at a time, and
// tags returning results with their lane. ACC_SCHED_FIXED_PRIO_EN selects fixed priority.
module acc_sched
  import acc_sched_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int TERMS       = 2,
  parameter int ACC_LATENCY = 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [LANES-1:0]              REQ_VALID,
  input  logic [LANES-1:0][FP16_W-1:0]  REQ_DATA,
  input  logic [LANES-1:0][TYPE_W-1:0]  REQ_TYPE,
  output logic [LANES-1:0]              REQ_READY,
  output logic                          ACC_DVI,
  output logic                          ACC_RELEASE,
  output logic [FP16_W-1:0]             ACC_DI,
  output logic [TYPE_W-1:0]             ACC_DI_TYPE,
  input  logic                          ACC_DVO,
  input  logic [FP16_W-1:0]             ACC_DO,
  input  logic [TYPE_W-1:0]             ACC_DO_TYPE,
  output logic                          RES_VALID,
  output logic [LANE_W-1:0]             RES_LANE,
  output logic [FP16_W-1:0]             RES_DATA,
  output logic [TYPE_W-1:0]             RES_TYPE,
  output logic                          BUSY,
  output logic                          ERR
);

  localparam int CNT_W = 6;

  state_e                     state_q, state_d;
  logic [LANE_W-1:0]          lane_q, lane_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       err_q, err_d;
  tag_t [ACC_LATENCY-1:0]     tagPipe_q;
  tag_t                       tagIn, tail;

  logic [LANES-1:0]           arbGnt;
  logic [LANE_W-1:0]          arbIdx;
  logic                       arbAny;
  logic [LANE_W-1:0]          arbPtr;

  logic [LANES-1:0]           laneOneHot, readyVec;
  logic                       laneValid, fire, isLast, relTerm, anyVld;
  logic [LANE_W-1:0]          grantLane;
  logic [FP16_W-1:0]          selData;
  logic [TYPE_W-1:0]          selType;

`ifdef ACC_SCHED_FIXED_PRIO_EN
  assign arbPtr = '0;
`else
  logic [LANE_W-1:0]          rrPtr_q, rrPtr_d;
  assign arbPtr = rrPtr_q;
`endif

  rr_arbiter #(.LANES(LANES)) u_arb (
    .req_i (REQ_VALID),
    .ptr_i (arbPtr),
    .gnt_o (arbGnt),
    .idx_o (arbIdx),
    .any_o (arbAny)
  );

  assign tail = tagPipe_q[ACC_LATENCY-1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      lane_q    <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      tagPipe_q <= '0;
`ifndef ACC_SCHED_FIXED_PRIO_EN
      rrPtr_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      lane_q       <= lane_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      tagPipe_q[0] <= tagIn;
      for (int i = 1; i < ACC_LATENCY; i++) tagPipe_q[i] <= tagPipe_q[i-1];
`ifndef ACC_SCHED_FIXED_PRIO_EN
      rrPtr_q      <= rrPtr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    cnt_d   = cnt_q;
    err_d   = err_q | (ACC_DVO != tail.vld);
`ifndef ACC_SCHED_FIXED_PRIO_EN
    rrPtr_d = rrPtr_q;
`endif
    if (fire) begin
      lane_d = grantLane;
      if (isLast) begin
        state_d = IDLE;
        cnt_d   = '0;
`ifndef ACC_SCHED_FIXED_PRIO_EN
        rrPtr_d = nextLane(grantLane, LANES);
`endif
      end else begin
        state_d = BURST;
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  // While a burst is open only the locked lane can move; nothing is accepted during reset.
  always_comb begin
    laneOneHot = LANES'(1) << lane_q;
    laneValid  = |(REQ_VALID & laneOneHot);
    grantLane  = lane_q;
    fire       = 1'b0;
    readyVec   = '0;
    isLast     = 1'b0;
    relTerm    = 1'b0;
    if (!RST) begin
      case (state_q)
        IDLE: begin
          grantLane = arbIdx;
          fire      = arbAny;
          readyVec  = arbGnt;
          relTerm   = arbAny;
          isLast    = arbAny && (TERMS == 1);
        end
        BURST: begin
          fire     = laneValid;
          readyVec = laneValid ? laneOneHot : '0;
          isLast   = laneValid && (cnt_q == CNT_W'(TERMS - 1));
        end
        default: ;
      endcase
    end

    selData = '0;
    selType = '0;
    for (int i = 0; i < LANES; i++) begin
      if (fire && (grantLane == LANE_W'(i))) begin
        selData = REQ_DATA[i];
        selType = REQ_TYPE[i];
      end
    end

    tagIn.vld  = fire;
    tagIn.last = isLast;
    tagIn.lane = grantLane;

    anyVld = 1'b0;
    for (int i = 0; i < ACC_LATENCY; i++) anyVld = anyVld | tagPipe_q[i].vld;
  end

  assign REQ_READY   = readyVec;
  assign ACC_DVI     = fire;
  assign ACC_RELEASE = relTerm;
  assign ACC_DI      = selData;
  assign ACC_DI_TYPE = selType;

  assign RES_VALID   = !RST && ACC_DVO && tail.vld && tail.last;
  assign RES_LANE    = RST ? '0 : tail.lane;
  assign RES_DATA    = ACC_DO;
  assign RES_TYPE    = ACC_DO_TYPE;
  assign BUSY        = !RST && ((state_q == BURST) || anyVld);
  assign ERR         = !RST && err_q;

endmodule

// File: tb/tb_acc_sched.sv
// Directed bench for acc_sched with behavioural accumulator stand-ins; instance A uses
// TERMS=2/latency 1, instance B uses TERMS=1/latency 3.
module tb_acc_sched;
  import acc_sched_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic injDvo = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  logic [3:0]        reqValidA = '0;
  logic [3:0][15:0]  reqDataA  = '0;
  logic [3:0][5:0]   reqTypeA  = {4{TYPE_NORM}};
  logic [3:0]        reqReadyA;
  logic              accDviA, accRelA, accDvoA, resValidA, busyA, errA;
  logic [15:0]       accDiA, resDataA;
  logic [5:0]        accDiTypeA, resTypeA;
  logic [2:0]        resLaneA;
  logic              modelDvoA = 1'b0;
  logic [15:0]       modelDoA = '0;
  logic [5:0]        modelDoTypeA = '0;
  real               accSum = 0.0;

  logic [3:0]        reqValidB = '0;
  logic [3:0][15:0]  reqDataB  = {16'h4400, 16'h4200, 16'h4000, 16'h3C00};
  logic [3:0][5:0]   reqTypeB  = {4{TYPE_NORM}};
  logic [3:0]        reqReadyB;
  logic              accDviB, accRelB, resValidB, busyB, errB;
  logic [15:0]       accDiB, resDataB;
  logic [5:0]        accDiTypeB, resTypeB;
  logic [2:0]        resLaneB;
  logic [2:0]        bVldPipe = '0;
  logic [2:0][15:0]  bDataPipe = '0;

  assign accDvoA = modelDvoA | injDvo;

  acc_sched #(.LANES(4), .TERMS(2), .ACC_LATENCY(1)) dutA (
    .CLK(clk), .RST(rst), .REQ_VALID(reqValidA), .REQ_DATA(reqDataA), .REQ_TYPE(reqTypeA),
    .REQ_READY(reqReadyA), .ACC_DVI(accDviA), .ACC_RELEASE(accRelA), .ACC_DI(accDiA),
    .ACC_DI_TYPE(accDiTypeA), .ACC_DVO(accDvoA), .ACC_DO(modelDoA), .ACC_DO_TYPE(modelDoTypeA),
    .RES_VALID(resValidA), .RES_LANE(resLaneA), .RES_DATA(resDataA), .RES_TYPE(resTypeA),
    .BUSY(busyA), .ERR(errA)
  );

  acc_sched #(.LANES(4), .TERMS(1), .ACC_LATENCY(3)) dutB (
    .CLK(clk), .RST(rst), .REQ_VALID(reqValidB), .REQ_DATA(reqDataB), .REQ_TYPE(reqTypeB),
    .REQ_READY(reqReadyB), .ACC_DVI(accDviB), .ACC_RELEASE(accRelB), .ACC_DI(accDiB),
    .ACC_DI_TYPE(accDiTypeB), .ACC_DVO(bVldPipe[2]), .ACC_DO(bDataPipe[2]), .ACC_DO_TYPE(TYPE_NORM),
    .RES_VALID(resValidB), .RES_LANE(resLaneB), .RES_DATA(resDataB), .RES_TYPE(resTypeB),
    .BUSY(busyB), .ERR(errB)
  );

  function automatic real fp16ToReal(input logic [15:0] h);
    int  e;
    real v;
    if (h[14:10] == 5'd0) return 0.0;
    e = int'(h[14:10]) - 15;
    v = 1.0 + real'(h[9:0]) / 1024.0;
    while (e > 0) begin v = v * 2.0; e--; end
    while (e < 0) begin v = v / 2.0; e++; end
    return v;
  endfunction

  function automatic logic [15:0] realToFp16(input real r);
    int  e;
    real m;
    if (r == 0.0) return 16'h0000;
    e = 15;
    m = r;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    return {1'b0, 5'(e), 10'($rtoi((m - 1.0) * 1024.0))};
  endfunction

  function automatic real sumNext(input logic rel, input real sum, input logic [15:0] di);
    return rel ? fp16ToReal(di) : sum + fp16ToReal(di);
  endfunction

  // Accumulator stand-in for A: running sum restarted by RELEASE, one DVO per DVI a cycle later.
  always @(posedge clk) begin
    if (rst) begin
      modelDvoA <= 1'b0;
      accSum    <= 0.0;
    end else if (accDviA) begin
      accSum       <= sumNext(accRelA, accSum, accDiA);
      modelDvoA    <= 1'b1;
      modelDoA     <= realToFp16(sumNext(accRelA, accSum, accDiA));
      modelDoTypeA <= (sumNext(accRelA, accSum, accDiA) == 0.0) ? TYPE_ZERO : TYPE_NORM;
    end else begin
      modelDvoA <= 1'b0;
    end
  end

  // Stand-in for B: every burst is one term, so the sum is the term delayed three cycles.
  always @(posedge clk) begin
    if (rst) bVldPipe <= '0;
    else begin
      bVldPipe  <= {bVldPipe[1:0], accDviB};
      bDataPipe <= {bDataPipe[1:0], accDiB};
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset;
    cyc();
    rst = 1'b1;
    reqValidA = '0;
    reqValidB = '0;
    injDvo = 1'b0;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    reqValidA = 4'b1111;
    reqValidB = 4'b1111;
    cyc();
    cyc();
    #1;
    total++; if (reqReadyA !== 4'b0000) begin bad++; $display("[TB] FAIL reset_ready got=%b exp=0000", reqReadyA); end
    total++; if (accDviA !== 1'b0) begin bad++; $display("[TB] FAIL reset_dvi got=%b exp=0", accDviA); end
    total++; if (resValidA !== 1'b0) begin bad++; $display("[TB] FAIL reset_resvalid got=%b exp=0", resValidA); end
    total++; if (busyA !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b exp=0", busyA); end
    total++; if (errA !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%b exp=0", errA); end
    total++; if (reqReadyB !== 4'b0000) begin bad++; $display("[TB] FAIL reset_readyB got=%b exp=0000", reqReadyB); end
    reqValidA = '0;
    reqValidB = '0;
    rst = 1'b0;
  endtask

  task automatic test_single_lane;
    doReset();
    cyc();
    reqValidA = 4'b0010;
    reqDataA[1] = 16'h3C00;
    #1;
    total++; if (reqReadyA !== 4'b0010) begin bad++; $display("[TB] FAIL single_ready0 got=%b exp=0010", reqReadyA); end
    total++; if (accRelA !== 1'b1) begin bad++; $display("[TB] FAIL single_rel0 got=%b exp=1", accRelA); end
    total++; if (accDiA !== 16'h3C00) begin bad++; $display("[TB] FAIL single_di0 got=%h exp=3c00", accDiA); end
    total++; if (accDiTypeA !== TYPE_NORM) begin bad++; $display("[TB] FAIL single_ditype got=%b exp=%b", accDiTypeA, TYPE_NORM); end
    cyc();
    reqDataA[1] = 16'h4000;
    #1;
    total++; if (reqReadyA !== 4'b0010) begin bad++; $display("[TB] FAIL single_ready1 got=%b exp=0010", reqReadyA); end
    total++; if (accRelA !== 1'b0) begin bad++; $display("[TB] FAIL single_rel1 got=%b exp=0", accRelA); end
    total++; if (accDiA !== 16'h4000) begin bad++; $display("[TB] FAIL single_di1 got=%h exp=4000", accDiA); end
    total++; if (resValidA !== 1'b0) begin bad++; $display("[TB] FAIL single_partial got=%b exp=0", resValidA); end
    total++; if (busyA !== 1'b1) begin bad++; $display("[TB] FAIL single_busy got=%b exp=1", busyA); end
    cyc();
    reqValidA = 4'b0000;
    #1;
    total++; if (resValidA !== 1'b1) begin bad++; $display("[TB] FAIL single_resvalid got=%b exp=1", resValidA); end
    total++; if (resLaneA !== 3'd1) begin bad++; $display("[TB] FAIL single_lane got=%0d exp=1", resLaneA); end
    total++; if (resDataA !== 16'h4200) begin bad++; $display("[TB] FAIL single_data got=%h exp=4200", resDataA); end
    total++; if (resTypeA !== TYPE_NORM) begin bad++; $display("[TB] FAIL single_type got=%b exp=%b", resTypeA, TYPE_NORM); end
    total++; if (accDiA !== 16'h0000) begin bad++; $display("[TB] FAIL single_di_idle got=%h exp=0000", accDiA); end
    cyc();
    #1;
    total++; if (resValidA !== 1'b0) begin bad++; $display("[TB] FAIL single_pulse got=%b exp=0", resValidA); end
    total++; if (busyA !== 1'b0) begin bad++; $display("[TB] FAIL single_idle_busy got=%b exp=0", busyA); end
    total++; if (errA !== 1'b0) begin bad++; $display("[TB] FAIL single_err got=%b exp=0", errA); end
  endtask

  task automatic test_two_lanes;
`ifdef ACC_SCHED_FIXED_PRIO_EN
    logic [3:0] rdyTbl [9] = '{4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1};
    logic [2:0] laneTbl[9] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
`else
    logic [3:0] rdyTbl [9] = '{4'h1, 4'h1, 4'h4, 4'h4, 4'h1, 4'h1, 4'h4, 4'h4, 4'h1};
    logic [2:0] laneTbl[9] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd0, 3'd0, 3'd0, 3'd2};
`endif
    logic       vldTbl [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    doReset();
    for (int c = 0; c < 9; c++) begin
      cyc();
      reqValidA = 4'b0101;
      reqDataA[0] = 16'h3C00;
      reqDataA[2] = 16'h3C00;
      #1;
      total++; if (reqReadyA !== rdyTbl[c]) begin bad++; $display("[TB] FAIL two_ready c%0d got=%b exp=%b", c, reqReadyA, rdyTbl[c]); end
      total++; if (resValidA !== vldTbl[c]) begin bad++; $display("[TB] FAIL two_resvalid c%0d got=%b exp=%b", c, resValidA, vldTbl[c]); end
      if (vldTbl[c]) begin
        total++; if (resLaneA !== laneTbl[c]) begin bad++; $display("[TB] FAIL two_lane c%0d got=%0d exp=%0d", c, resLaneA, laneTbl[c]); end
        total++; if (resDataA !== 16'h4000) begin bad++; $display("[TB] FAIL two_data c%0d got=%h exp=4000", c, resDataA); end
      end
    end
  endtask

  task automatic test_gap;
    doReset();
    cyc();
    reqValidA = 4'b1000;
    reqDataA[3] = 16'h3C00;
    #1;
    total++; if (reqReadyA !== 4'b1000) begin bad++; $display("[TB] FAIL gap_ready0 got=%b exp=1000", reqReadyA); end
    total++; if (accRelA !== 1'b1) begin bad++; $display("[TB] FAIL gap_rel0 got=%b exp=1", accRelA); end
    for (int c = 1; c < 4; c++) begin
      cyc();
      reqValidA = 4'b0001;
      reqDataA[0] = 16'h4000;
      #1;
      total++; if (reqReadyA !== 4'b0000) begin bad++; $display("[TB] FAIL gap_stall c%0d got=%b exp=0000", c, reqReadyA); end
      total++; if (accDviA !== 1'b0) begin bad++; $display("[TB] FAIL gap_dvi c%0d got=%b exp=0", c, accDviA); end
      total++; if (resValidA !== 1'b0) begin bad++; $display("[TB] FAIL gap_res c%0d got=%b exp=0", c, resValidA); end
    end
    cyc();
    reqValidA = 4'b1001;
    reqDataA[3] = 16'h4200;
    #1;
    total++; if (reqReadyA !== 4'b1000) begin bad++; $display("[TB] FAIL gap_ready4 got=%b exp=1000", reqReadyA); end
    total++; if (accRelA !== 1'b0) begin bad++; $display("[TB] FAIL gap_rel4 got=%b exp=0", accRelA); end
    total++; if (accDiA !== 16'h4200) begin bad++; $display("[TB] FAIL gap_di4 got=%h exp=4200", accDiA); end
    cyc();
    reqValidA = 4'b0001;
    #1;
    total++; if (resValidA !== 1'b1) begin bad++; $display("[TB] FAIL gap_resvalid got=%b exp=1", resValidA); end
    total++; if (resLaneA !== 3'd3) begin bad++; $display("[TB] FAIL gap_lane got=%0d exp=3", resLaneA); end
    total++; if (resDataA !== 16'h4400) begin bad++; $display("[TB] FAIL gap_data got=%h exp=4400", resDataA); end
    total++; if (reqReadyA !== 4'b0001) begin bad++; $display("[TB] FAIL gap_next got=%b exp=0001", reqReadyA); end
  endtask

  task automatic test_reset_mid;
    doReset();
    cyc();
    reqValidA = 4'b0100;
    reqDataA[2] = 16'h4000;
    #1;
    total++; if (accRelA !== 1'b1) begin bad++; $display("[TB] FAIL mid_rel0 got=%b exp=1", accRelA); end
    cyc();
    rst = 1'b1;
    reqValidA = 4'b0000;
    #1;
    total++; if (accDviA !== 1'b0) begin bad++; $display("[TB] FAIL mid_dvi_rst got=%b exp=0", accDviA); end
    cyc();
    rst = 1'b0;
    #1;
    total++; if (resValidA !== 1'b0) begin bad++; $display("[TB] FAIL mid_res got=%b exp=0", resValidA); end
    total++; if (busyA !== 1'b0) begin bad++; $display("[TB] FAIL mid_busy got=%b exp=0", busyA); end
    cyc();
    reqValidA = 4'b0010;
    reqDataA[1] = 16'h3C00;
    #1;
    total++; if (reqReadyA !== 4'b0010) begin bad++; $display("[TB] FAIL mid_ready got=%b exp=0010", reqReadyA); end
    total++; if (accRelA !== 1'b1) begin bad++; $display("[TB] FAIL mid_rel1 got=%b exp=1", accRelA); end
    cyc();
    #1;
    total++; if (accRelA !== 1'b0) begin bad++; $display("[TB] FAIL mid_rel2 got=%b exp=0", accRelA); end
    cyc();
    reqValidA = 4'b0000;
    #1;
    total++; if (resValidA !== 1'b1) begin bad++; $display("[TB] FAIL mid_resvalid got=%b exp=1", resValidA); end
    total++; if (resLaneA !== 3'd1) begin bad++; $display("[TB] FAIL mid_lane got=%0d exp=1", resLaneA); end
    total++; if (resDataA !== 16'h4000) begin bad++; $display("[TB] FAIL mid_data got=%h exp=4000", resDataA); end
  endtask

  task automatic test_back_to_back;
    logic [3:0]  maskTbl[8] = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [3:0]  rdyTbl [8] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};
    logic        vldTbl [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0]  laneTbl[8] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    logic [15:0] dataTbl[8] = '{16'h0, 16'h0, 16'h0, 16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h0};
    doReset();
    for (int c = 0; c < 8; c++) begin
      cyc();
      reqValidB = maskTbl[c];
      #1;
      total++; if (reqReadyB !== rdyTbl[c]) begin bad++; $display("[TB] FAIL b2b_ready c%0d got=%b exp=%b", c, reqReadyB, rdyTbl[c]); end
      total++; if (resValidB !== vldTbl[c]) begin bad++; $display("[TB] FAIL b2b_resvalid c%0d got=%b exp=%b", c, resValidB, vldTbl[c]); end
      if (vldTbl[c]) begin
        total++; if (resLaneB !== laneTbl[c]) begin bad++; $display("[TB] FAIL b2b_lane c%0d got=%0d exp=%0d", c, resLaneB, laneTbl[c]); end
        total++; if (resDataB !== dataTbl[c]) begin bad++; $display("[TB] FAIL b2b_data c%0d got=%h exp=%h", c, resDataB, dataTbl[c]); end
      end
    end
    total++; if (errB !== 1'b0) begin bad++; $display("[TB] FAIL b2b_err got=%b exp=0", errB); end
    total++; if (busyB !== 1'b0) begin bad++; $display("[TB] FAIL b2b_busy got=%b exp=0", busyB); end
  endtask

  task automatic test_err;
    doReset();
    cyc();
    injDvo = 1'b1;
    #1;
    total++; if (errA !== 1'b0) begin bad++; $display("[TB] FAIL err_before got=%b exp=0", errA); end
    total++; if (resValidA !== 1'b0) begin bad++; $display("[TB] FAIL err_res got=%b exp=0", resValidA); end
    cyc();
    injDvo = 1'b0;
    #1;
    total++; if (errA !== 1'b1) begin bad++; $display("[TB] FAIL err_set got=%b exp=1", errA); end
    cyc();
    cyc();
    #1;
    total++; if (errA !== 1'b1) begin bad++; $display("[TB] FAIL err_sticky got=%b exp=1", errA); end
    doReset();
    cyc();
    #1;
    total++; if (errA !== 1'b0) begin bad++; $display("[TB] FAIL err_clear got=%b exp=0", errA); end
  endtask

  initial begin
    $display("[TB] acc_sched directed tests");
    test_reset();
    test_single_lane();
    test_two_lanes();
    test_gap();
    test_reset_mid();
    test_back_to_back();
    test_err();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
